// File: rtl/cdc_handshake_tx.sv
// rtl/cdc_handshake_tx.sv - source end of a four-phase req/ack clock-domain crossing
`timescale 1ns/100ps
module cdc_handshake_tx #(
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              req_out,
    output logic [DATA_W-1:0] data_out,
    input  logic              ack_in,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;

    localparam bit          TO_EN   = (TIMEOUT > 0);
    localparam logic [15:0] TO_LAST = TO_EN ? 16'(TIMEOUT - 1) : 16'd0;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;
    logic                   req_nxt;
    logic [DATA_W-1:0]      data_nxt;
    logic                   done_nxt;
    logic                   err_nxt;
    logic [15:0]            cnt, cnt_nxt;
    logic                   tout, tout_nxt;
    logic                   to_hit;

    assign ack_s    = ack_sync[SYNC_STAGES-1];
    assign to_hit   = TO_EN && (cnt == TO_LAST);
    assign in_ready = (state == IDLE) && !ack_s && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ack_sync <= '0;
            req_out  <= 1'b0;
            data_out <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            cnt      <= 16'd0;
            tout     <= 1'b0;
        end else begin
            state    <= state_nxt;
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_in};
            req_out  <= req_nxt;
            data_out <= data_nxt;
            done     <= done_nxt;
            err      <= err_nxt;
            cnt      <= cnt_nxt;
            tout     <= tout_nxt;
        end
    end

    // tout remembers that the current transfer was abandoned, so its release phase
    // must not report completion even though err itself is sticky across transfers.
    always_comb begin
        state_nxt = state;
        req_nxt   = req_out;
        data_nxt  = data_out;
        done_nxt  = 1'b0;
        err_nxt   = err;
        cnt_nxt   = cnt;
        tout_nxt  = tout;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    data_nxt  = in_data;
                    req_nxt   = 1'b1;
                    cnt_nxt   = 16'd0;
                    tout_nxt  = 1'b0;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (ack_s) begin
                    req_nxt   = 1'b0;
                    cnt_nxt   = 16'd0;
                    state_nxt = RELEASE;
                end else if (to_hit) begin
                    err_nxt   = 1'b1;
                    req_nxt   = 1'b0;
                    cnt_nxt   = 16'd0;
                    tout_nxt  = 1'b1;
                    state_nxt = RELEASE;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            RELEASE: begin
                if (!ack_s) begin
                    done_nxt  = !tout;
                    state_nxt = IDLE;
                end else if (to_hit) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: doc/cdc_handshake_tx.md
Name: cdc_handshake_tx

Overview:
- Source end of a four-phase req/ack clock-domain crossing. Transfers a data word from the local `clk` domain to a destination in an unrelated clock domain.
- The destination brings `req_out` into its own domain through a flop-chain synchronizer. It returns `ack_in` asynchronously.
- This block synchronizes `ack_in` internally, holds `data_out` stable for the whole handshake, and offers a valid/ready interface to local logic.
- Used wherever core-side logic (e.g. CSR or peripheral writes) must hand a word to a slower or foreign-clock peripheral.

Parameters:
- DATA_W, 32, width of the transferred word.
- SYNC_STAGES, 2, number of flops on the `ack_in` synchronizer chain; legal range 2..4.
- TIMEOUT, 0, clk cycles to wait in REQ or RELEASE before flagging an error; 0 disables the timeout. Counter width is 16 bits, so max 65535.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous and active-high.
- in_valid  input  1  local word available.
- in_data  input  DATA_W  local word.
- in_ready  output  1  block can accept a word this cycle.
- req_out  output  1  registered request to the destination domain.
- data_out  output  DATA_W  registered data; stable whenever `req_out`=1 and until `ack_s` returns to 0.
- ack_in  input  1  asynchronous acknowledge from the destination.
- done  output  1  one-cycle pulse when a transfer completes.
- err  output  1  sticky timeout flag; cleared only by `rst`.

Behaviour:
- Reset, sampled on posedge `clk` when `rst`=1:
  - state=IDLE; sync chain cleared to 0; `ack_s`=0.
  - `req_out`=0, `data_out`=0, `done`=0, `err`=0, timeout counter=0.
  - `in_ready` is 0 during reset.
- Synchronizer: `ack_in` passes through SYNC_STAGES flops; `ack_s` is the last stage. A change on `ack_in` becomes visible in `ack_s` after SYNC_STAGES rising edges.
- `in_ready` is combinational: (state==IDLE) && (`ack_s`==0) && !`rst`.
- IDLE:
  - On an edge with `in_valid` && `in_ready`: `data_out`<=`in_data`, `req_out`<=1, counter<=0, state<=REQ.
  - `req_out` is high the cycle after acceptance.
  - A stale `ack_s`=1 in IDLE blocks acceptance until it drops.
- REQ:
  - If `ack_s`==1: `req_out`<=0, counter<=0, state<=RELEASE.
  - Else, when TIMEOUT>0 and counter==TIMEOUT-1: `err`<=1, `req_out`<=0, counter<=0, state<=RELEASE.
  - Otherwise counter increments.
  - `data_out` is held.
- RELEASE:
  - If `ack_s`==0: state<=IDLE, and `done`<=1 for exactly one cycle, but only if this transfer did not time out.
  - Else, when TIMEOUT>0 and counter==TIMEOUT-1: `err`<=1, state<=IDLE, no `done`.
  - Otherwise counter increments.
  - `data_out` is held until leaving RELEASE.
- Minimum round trip: 2·SYNC_STAGES + 2 edges from acceptance to the `done` pulse, with an instant external ack.
- `in_data` and `in_valid` are ignored outside IDLE. There is no buffering; back-to-back words wait for `in_ready`.
- Reset mid-transfer: `req_out` drops on that edge and the state returns to IDLE. The destination sees the request deassert.
- `done` and the next acceptance may not occur on the same edge, because acceptance requires state==IDLE beforehand.
- `err` is never cleared except by `rst`.

Test Plan:
- Basic transfer, SYNC_STAGES=2, TIMEOUT=0: send 0xDEADBEEF with ack model echoing `req_out` after 3 cycles.
  - Required: `req_out` rises 1 cycle after accept; `data_out`=0xDEADBEEF stable throughout; `done` is a single pulse; `in_ready` returns to 1 the same cycle as `done`.
- Back-to-back: hold `in_valid`=1 with words 0x1, 0x2, 0x3.
  - Required: exactly three `done` pulses; `data_out` sequence 1,2,3; no word captured while state≠IDLE; each accept-to-`done` takes ≥6 cycles.
- Stale ack: hold `ack_in`=1 after reset for 10 cycles with `in_valid`=1.
  - Required: `in_ready`=0 and `req_out`=0 until 2 cycles after `ack_in` falls, then the word is accepted.
- Timeout, TIMEOUT=8: never assert `ack_in`.
  - Required: `req_out` high for exactly 8 cycles, then `err`=1 sticky, `req_out`=0, no `done`, `in_ready`=1 once back in IDLE.
- Reset mid-handshake: assert `rst` for 1 cycle while in REQ.
  - Required: next cycle `req_out`=0, `data_out`=0, `done`=0, `err`=0, and a fresh transfer completes normally.
- Async ack jitter: toggle `ack_in` at random non-clk-aligned times with a compliant 4-phase destination model for 1000 transfers.
  - Required: every transfer yields one `done`; `data_out` never changes while `req_out`=1 or `ack_s`=1.
